// File: rtl/ram_obi.sv
// Single-port data RAM with req/gnt/rvalid handshake, byte enables,
// configurable read latency, range checking and optional zero-init sweep.
module ram_obi #(
  parameter int DataWidth   = 32,
  parameter int Depth       = 4096,
  parameter int AddrWidth   = 32,
  parameter int ReadLatency = 1,
  parameter int InitZero    = 1
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   req_i,
  output logic                   gnt_o,
  input  logic                   we_i,
  input  logic [DataWidth/8-1:0] be_i,
  input  logic [AddrWidth-1:0]   addr_i,
  input  logic [DataWidth-1:0]   wdata_i,
  output logic                   rvalid_o,
  output logic [DataWidth-1:0]   rdata_o,
  output logic                   err_o,
  output logic                   init_done_o
);

  localparam int NB = DataWidth / 8;
  localparam int B  = $clog2(NB);
  localparam int IW = $clog2(Depth);

  typedef enum logic {
    S_INIT,
    S_READY
  } state_e;

  state_e               r_state;
  logic [IW-1:0]        r_cnt;
  logic [DataWidth-1:0] r_mem [Depth];

  logic [ReadLatency-1:0] r_vld;
  logic [ReadLatency-1:0] r_err;
  logic [DataWidth-1:0]   r_dat [ReadLatency];

  logic          w_xfer;
  logic          w_oor;
  logic          w_wr;
  logic          w_rd;
  logic          w_ready;
  logic [IW-1:0] w_idx;

  assign w_idx   = addr_i[IW+B-1:B];
  assign w_oor   = (addr_i >> (IW + B)) != '0;
  // Held low while reset is asserted, high on the first cycle after release.
  assign w_ready = (r_state == S_READY) && rst_ni;
  assign w_xfer  = req_i && w_ready;
  assign w_wr    = w_xfer && we_i && !w_oor;
  assign w_rd    = w_xfer && !we_i && !w_oor;

  assign gnt_o       = w_ready;
  assign init_done_o = w_ready;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state <= (InitZero != 0) ? S_INIT : S_READY;
      r_cnt   <= '0;
    end else if (r_state == S_INIT) begin
      r_cnt <= r_cnt + 1'b1;
      if (r_cnt == IW'(Depth - 1)) begin
        r_state <= S_READY;
      end
    end
  end

  // Storage is deliberately not reset so contents survive reset.
  always_ff @(posedge clk_i) begin
    if (r_state == S_INIT) begin
      r_mem[r_cnt] <= '0;
    end else if (w_wr) begin
      for (int i = 0; i < NB; i++) begin
        if (be_i[i]) begin
          r_mem[w_idx][8*i +: 8] <= wdata_i[8*i +: 8];
        end
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_vld <= '0;
      r_err <= '0;
      for (int i = 0; i < ReadLatency; i++) begin
        r_dat[i] <= '0;
      end
    end else begin
      r_vld[0] <= w_xfer;
      r_err[0] <= w_xfer && w_oor;
      r_dat[0] <= w_rd ? r_mem[w_idx] : '0;
      for (int i = 1; i < ReadLatency; i++) begin
        r_vld[i] <= r_vld[i-1];
        r_err[i] <= r_err[i-1];
        r_dat[i] <= r_dat[i-1];
      end
    end
  end

  assign rvalid_o = r_vld[ReadLatency-1];
  assign err_o    = r_err[ReadLatency-1];
  assign rdata_o  = r_dat[ReadLatency-1];

endmodule

// File: tb/tb_ram_obi.sv
// Bench for ram_obi: four instances (latency 1..4) share one stimulus
// stream and are checked against a per-instance memory/response model.
module tb_ram_obi;

  logic        clk;
  logic        rst_n;
  logic        req;
  logic        we;
  logic [3:0]  be;
  logic [31:0] addr;
  logic [31:0] wdata;

  logic        gnt    [4];
  logic        rvalid [4];
  logic        err    [4];
  logic        idone  [4];
  logic [31:0] rdata  [4];

  for (genvar k = 0; k < 4; k++) begin : g_dut
    ram_obi #(
      .DataWidth  (32),
      .Depth      (16),
      .AddrWidth  (32),
      .ReadLatency(k + 1),
      .InitZero   ((k == 2) ? 0 : 1)
    ) u_dut (
      .clk_i      (clk),
      .rst_ni     (rst_n),
      .req_i      (req),
      .gnt_o      (gnt[k]),
      .we_i       (we),
      .be_i       (be),
      .addr_i     (addr),
      .wdata_i    (wdata),
      .rvalid_o   (rvalid[k]),
      .rdata_o    (rdata[k]),
      .err_o      (err[k]),
      .init_done_o(idone[k])
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;
  int cyc    = 0;
  int cnt    = 0;

  // Model: word contents and expected responses keyed by due cycle.
  logic [31:0] m  [4][16];
  bit          ev [4][8];
  bit          ee [4][8];
  logic [31:0] ed [4][8];

  task automatic chk(input string tag, input int k,
                     input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s[%0d] observed=%h expected=%h", tag, k, obs, exp);
    end
  endtask

  function automatic bit rdy(input int k);
    return rst_n && ((k == 2) || (cnt >= 16));
  endfunction

  task automatic step(input bit rq, input bit w, input logic [3:0] b,
                      input logic [31:0] a, input logic [31:0] d);
    int          ix;
    int          s;
    bit          oor;
    logic [31:0] r;
    bit          g [4];
    req = rq; we = w; be = b; addr = a; wdata = d;
    for (int k = 0; k < 4; k++) g[k] = rdy(k);
    @(posedge clk);
    oor = (a >= 32'd64);
    ix  = int'(a[5:2]);
    for (int k = 0; k < 4; k++) begin
      if (rq && g[k]) begin
        r = '0;
        if (!oor) begin
          if (w) begin
            for (int i = 0; i < 4; i++)
              if (b[i]) m[k][ix][8*i +: 8] = d[8*i +: 8];
          end else begin
            r = m[k][ix];
          end
        end
        s = (cyc + k) % 8;
        ev[k][s] = 1'b1;
        ee[k][s] = oor;
        ed[k][s] = r;
      end
    end
    cnt++;
    @(negedge clk);
    req = 1'b0;
    s = cyc % 8;
    for (int k = 0; k < 4; k++) begin
      chk("gnt", k, 32'(gnt[k]), 32'(rdy(k)));
      chk("init_done", k, 32'(idone[k]), 32'(rdy(k)));
      chk("rvalid", k, 32'(rvalid[k]), 32'(ev[k][s]));
      chk("err", k, 32'(err[k]), ev[k][s] ? 32'(ee[k][s]) : 32'd0);
      chk("rdata", k, rdata[k], ev[k][s] ? ed[k][s] : 32'd0);
      ev[k][s] = 1'b0;
    end
    cyc++;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    for (int k = 0; k < 4; k++) begin
      chk("rst_rvalid", k, 32'(rvalid[k]), 32'd0);
      chk("rst_err", k, 32'(err[k]), 32'd0);
      chk("rst_rdata", k, rdata[k], 32'd0);
      chk("rst_gnt", k, 32'(gnt[k]), 32'd0);
      chk("rst_idone", k, 32'(idone[k]), 32'd0);
      for (int j = 0; j < 8; j++) ev[k][j] = 1'b0;
      if (k != 2)
        for (int j = 0; j < 16; j++) m[k][j] = '0;
    end
    cnt = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    for (int k = 0; k < 4; k++)
      chk("rel_gnt", k, 32'(gnt[k]), 32'(rdy(k)));
  endtask

  initial begin
    rst_n = 1'b1;
    req = 1'b0; we = 1'b0; be = '0; addr = '0; wdata = '0;
    for (int k = 0; k < 4; k++)
      for (int j = 0; j < 8; j++) ev[k][j] = 1'b0;
    #2;
    do_reset();

    // Only the non-sweeping instance grants these; fills its memory.
    for (int i = 0; i < 16; i++)
      step(1'b1, 1'b1, 4'hF, 32'(i * 4), $urandom);

    step(1'b1, 1'b0, 4'h0, 32'h3C, 32'h0);
    step(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    chk("init_rd_v", 1, 32'(rvalid[1]), 32'd1);
    chk("init_rd_d", 1, rdata[1], 32'h0);

    step(1'b1, 1'b1, 4'hF, 32'h08, 32'hAABBCCDD);
    step(1'b1, 1'b1, 4'h5, 32'h08, 32'h11223344);
    step(1'b1, 1'b0, 4'h0, 32'h08, 32'h0);
    step(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    chk("be_rd", 1, rdata[1], 32'hAA22CC44);
    chk("be_err", 1, 32'(err[1]), 32'd0);

    step(1'b1, 1'b1, 4'hF, 32'h04, 32'hDEADBEEF);
    step(1'b1, 1'b0, 4'h0, 32'h04, 32'h0);
    chk("b2b_wr_v", 1, 32'(rvalid[1]), 32'd1);
    chk("b2b_wr_d", 1, rdata[1], 32'h0);
    step(1'b1, 1'b0, 4'h0, 32'h00, 32'h0);
    chk("b2b_rd1", 1, rdata[1], 32'hDEADBEEF);
    step(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    chk("b2b_rd2_v", 1, 32'(rvalid[1]), 32'd1);
    chk("b2b_rd2", 1, rdata[1], 32'h0);

    step(1'b1, 1'b0, 4'h0, 32'h40, 32'h0);
    step(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    chk("oor_rd_err", 1, 32'(err[1]), 32'd1);
    chk("oor_rd_d", 1, rdata[1], 32'h0);
    step(1'b1, 1'b1, 4'hF, 32'h40, 32'h12345678);
    step(1'b1, 1'b0, 4'h0, 32'h00, 32'h0);
    chk("oor_wr_err", 1, 32'(err[1]), 32'd1);
    step(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    chk("oor_rd0", 1, rdata[1], 32'h0);

    step(1'b1, 1'b0, 4'h0, 32'h08, 32'h0);
    chk("lat1", 0, 32'(rvalid[0]), 32'd1);
    for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);

    // Read in flight on the latency-3 instance is dropped by reset.
    step(1'b1, 1'b0, 4'h0, 32'h08, 32'h0);
    do_reset();
    chk("rst_first_gnt", 2, 32'(gnt[2]), 32'd1);
    step(1'b1, 1'b0, 4'h0, 32'h08, 32'h0);
    step(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    step(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    chk("rst_keep_v", 2, 32'(rvalid[2]), 32'd1);
    chk("rst_keep_d", 2, rdata[2], 32'hAA22CC44);

    for (int i = 0; i < 400; i++) begin
      logic [31:0] a;
      if (i == 200) do_reset();
      a = ($urandom_range(0, 9) == 0) ? $urandom : 32'($urandom_range(0, 79));
      step($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1,
           4'($urandom), a, $urandom);
    end
    for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
